hit_edge_timestamper: RTL and testbench

//  Consumes the 24 test-hit lines and the trigger line from the on-board hit generator and timestamps each

---
 rtl/tdc_emu_pkg.sv | 26 ++
 rtl/sync_fifo_fwft.sv | 60 ++++++
 rtl/hit_edge_timestamper.sv | 160 ++++++++++++++++
 tb/tb_hit_edge_timestamper.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_emu_pkg.sv
// Shared constants for the hit-generator timestamping path: marker codes, edge-select
// encodings and the bit layout of the stamped output word.
package tdc_emu_pkg;

  localparam int CH_W = 5;
  localparam logic [CH_W-1:0] TRIG_MARKER = 5'h1F;

  typedef enum logic [1:0] {
    EDGE_NONE  = 2'b00,
    EDGE_LEAD  = 2'b01,
    EDGE_TRAIL = 2'b10,
    EDGE_BOTH  = 2'b11
  } edge_sel_e;

  // Output word is {ch, trailing, coarse}; coarse sits at the bottom.
  localparam int OFS_COARSE = 0;

  function automatic int ofs_trail(input int cnt_w);
    return OFS_COARSE + cnt_w;
  endfunction

  function automatic int ofs_ch(input int cnt_w);
    return OFS_COARSE + cnt_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: array storage with a registered output stage.
// Occupancy counts the output register, so DEPTH words in total can be held.
module sync_fifo_fwft #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      mem_cnt_q, occ;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             do_wr, do_pop, do_load;

  assign occ     = mem_cnt_q + {{AW{1'b0}}, valid_q};
  assign full_o  = (occ == (AW+1)'(DEPTH));
  assign do_wr   = wr_en_i & ~full_o;
  assign do_pop  = valid_q & rd_en_i;
  // Refill the output stage whenever it is empty or being consumed this cycle.
  assign do_load = (mem_cnt_q != '0) & (~valid_q | do_pop);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_q + AW'(do_wr);
      mem_cnt_q <= mem_cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_load);
      if (do_load) begin
        data_q   <= mem[rd_ptr_q];
        valid_q  <= 1'b1;
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end else if (do_pop) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;

endmodule

// File: rtl/hit_edge_timestamper.sv
// Timestamps selected edges of the test-hit and trigger lines with a free-running coarse
// counter and serialises them (trigger first, then round-robin channels) into an output FIFO.
module hit_edge_timestamper
  import tdc_emu_pkg::*;
#(
  parameter int NCH        = 24,
  parameter int CNT_W      = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        hit_in,
  input  logic                  trigger_in,
  input  logic                  inv,
  input  logic                  enable,
  input  logic [NCH-1:0]        channel_mask,
  input  logic [1:0]            edge_sel,
  output logic [CH_W+CNT_W:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           lost_cnt,
  output logic                  lost_flag
);

  localparam int DW        = CH_W + 1 + CNT_W;
  localparam int OFS_TRAIL = ofs_trail(CNT_W);
  localparam int OFS_CH    = ofs_ch(CNT_W);

  logic [NCH-1:0]   h, lead, trail, hit_edge;
  logic [NCH-1:0]   h_q, pend_q, pend_d, grant, cap, lose;
  logic [CNT_W-1:0] ts_q [NCH];
  logic             type_q [NCH];
  logic             trig_h, trig_q, trig_edge;
  logic             trig_pend_q, trig_pend_d, trig_grant, trig_cap, trig_lose;
  logic [CNT_W-1:0] trig_ts_q;
  logic [CNT_W-1:0] coarse_q;
  logic [CH_W-1:0]  rr_q, rr_d, sel_idx, cand;
  logic             found;
  logic             fifo_full, wr_en;
  logic [DW-1:0]    wr_data;
  logic [15:0]      lost_q, lost_d;
  logic             lost_flag_q;
  logic [CH_W:0]    n_lost;
  logic [16:0]      lost_sum;
  edge_sel_e        sel_e;
  logic             lead_en, trail_en;

  assign sel_e    = edge_sel_e'(edge_sel);
  assign lead_en  = (sel_e == EDGE_LEAD)  || (sel_e == EDGE_BOTH);
  assign trail_en = (sel_e == EDGE_TRAIL) || (sel_e == EDGE_BOTH);

  assign h        = inv ? ~hit_in : hit_in;
  assign lead     = h & ~h_q;
  assign trail    = ~h & h_q;
  assign hit_edge = ((lead & {NCH{lead_en}}) | (trail & {NCH{trail_en}}))
                    & channel_mask & {NCH{enable}};

  assign trig_h    = inv ? ~trigger_in : trigger_in;
  assign trig_edge = trig_h & ~trig_q & enable;

  // A channel being drained this cycle may take a fresh edge without loss.
  assign cap         = hit_edge & (~pend_q | grant);
  assign lose        = hit_edge & pend_q & ~grant;
  assign pend_d      = (pend_q & ~grant) | cap;
  assign trig_cap    = trig_edge & (~trig_pend_q | trig_grant);
  assign trig_lose   = trig_edge & trig_pend_q & ~trig_grant;
  assign trig_pend_d = (trig_pend_q & ~trig_grant) | trig_cap;

  always_comb begin
    grant      = '0;
    trig_grant = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    rr_d       = rr_q;
    found      = 1'b0;
    sel_idx    = '0;
    cand       = '0;
    if (!fifo_full) begin
      if (trig_pend_q) begin
        trig_grant = 1'b1;
        wr_en      = 1'b1;
        wr_data[OFS_CH +: CH_W]         = TRIG_MARKER;
        wr_data[OFS_COARSE +: CNT_W]    = trig_ts_q;
      end else begin
        // First pending channel strictly after the last one served, wrapping.
        for (int i = 1; i <= NCH; i++) begin
          cand = CH_W'((int'(rr_q) + i) % NCH);
          if (!found && pend_q[cand]) begin
            found   = 1'b1;
            sel_idx = cand;
          end
        end
        if (found) begin
          grant[sel_idx] = 1'b1;
          wr_en          = 1'b1;
          rr_d           = sel_idx;
          wr_data[OFS_CH +: CH_W]      = sel_idx;
          wr_data[OFS_TRAIL]           = type_q[sel_idx];
          wr_data[OFS_COARSE +: CNT_W] = ts_q[sel_idx];
        end
      end
    end
  end

  assign n_lost   = (CH_W+1)'($countones(lose)) + {{CH_W{1'b0}}, trig_lose};
  assign lost_sum = {1'b0, lost_q} + 17'(n_lost);
  assign lost_d   = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q         <= '0;
      trig_q      <= 1'b0;
      coarse_q    <= '0;
      pend_q      <= '0;
      trig_pend_q <= 1'b0;
      trig_ts_q   <= '0;
      rr_q        <= CH_W'(NCH - 1);
      lost_q      <= '0;
      lost_flag_q <= 1'b0;
    end else begin
      h_q         <= h;
      trig_q      <= trig_h;
      coarse_q    <= coarse_q + CNT_W'(1);
      pend_q      <= pend_d;
      trig_pend_q <= trig_pend_d;
      if (trig_cap) trig_ts_q <= coarse_q;
      rr_q        <= rr_d;
      lost_q      <= lost_d;
      lost_flag_q <= lost_flag_q | (n_lost != '0);
    end
  end

  // Per-channel stamp storage; only meaningful while the matching pending bit is set.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_cap
    always_ff @(posedge clk) begin
      if (cap[gi]) begin
        ts_q[gi]   <= coarse_q;
        type_q[gi] <= trail[gi];
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .full_o     (fifo_full),
    .rd_en_i    (out_ready),
    .rd_data_o  (out_data),
    .rd_valid_o (out_valid)
  );

  assign lost_cnt  = lost_q;
  assign lost_flag = lost_flag_q;

endmodule

// File: tb/tb_hit_edge_timestamper.sv
// Randomised and directed bench for hit_edge_timestamper against a queue-based reference model.
module tb_hit_edge_timestamper;

  localparam int NCH   = 24;
  localparam int DEPTH = 16;
  localparam int DW    = 18;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] hit_in = '0;
  logic           trigger_in = 1'b0;
  logic           inv = 1'b0;
  logic           enable = 1'b1;
  logic [NCH-1:0] channel_mask = '1;
  logic [1:0]     edge_sel = 2'b01;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [15:0]    lost_cnt;
  logic           lost_flag;

  always #5 clk = ~clk;

  hit_edge_timestamper dut (
    .clk          (clk),
    .rst          (rst),
    .hit_in       (hit_in),
    .trigger_in   (trigger_in),
    .inv          (inv),
    .enable       (enable),
    .channel_mask (channel_mask),
    .edge_sel     (edge_sel),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .lost_cnt     (lost_cnt),
    .lost_flag    (lost_flag)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: words live in a queue tagged with the edge they entered the FIFO.
  typedef struct { logic [DW-1:0] w; int wc; } qent_t;
  qent_t         q[$];
  logic [DW-1:0] dut_log[$];
  bit            m_prev [NCH];
  bit            m_pend [NCH];
  int            m_ts   [NCH];
  bit            m_typ  [NCH];
  bit            m_tprev, m_tpend;
  int            m_tts, m_rr, m_coarse, m_lost, cyc;
  bit            m_flag;

  function automatic logic [DW-1:0] mkw(input int ch, input int tr, input int ts);
    logic [4:0]  c;
    logic        t;
    logic [11:0] s;
    c = ch[4:0];
    t = tr[0];
    s = ts[11:0];
    return {c, t, s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < NCH; c++) begin
      m_prev[c] = 0; m_pend[c] = 0; m_ts[c] = 0; m_typ[c] = 0;
    end
    m_tprev = 0; m_tpend = 0; m_tts = 0;
    m_rr = NCH - 1; m_coarse = 0; m_lost = 0; m_flag = 0;
  endtask

  task automatic model_edge();
    bit            vis, do_pop, full, have_word, cur, e;
    int            served, lost_n, c;
    bit            tserved;
    logic [DW-1:0] word;
    vis       = (q.size() > 0) && (cyc >= q[0].wc + 1);
    do_pop    = vis && out_ready;
    full      = (q.size() >= DEPTH);
    have_word = 0; served = -1; tserved = 0; word = '0; lost_n = 0;
    if (!full) begin
      if (m_tpend) begin
        have_word = 1; tserved = 1; word = mkw(31, 0, m_tts);
      end else begin
        for (int k = 1; k <= NCH; k++) begin
          c = (m_rr + k) % NCH;
          if (served < 0 && m_pend[c]) served = c;
        end
        if (served >= 0) begin
          have_word = 1;
          word = mkw(served, int'(m_typ[served]), m_ts[served]);
          m_rr = served;
        end
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      cur = inv ? !hit_in[ch] : hit_in[ch];
      e = enable && channel_mask[ch] &&
          ((cur && !m_prev[ch] && edge_sel[0]) || (!cur && m_prev[ch] && edge_sel[1]));
      if (served == ch) m_pend[ch] = 0;
      if (e) begin
        if (m_pend[ch]) lost_n++;
        else begin m_pend[ch] = 1; m_ts[ch] = m_coarse; m_typ[ch] = !cur; end
      end
      m_prev[ch] = cur;
    end
    cur = inv ? !trigger_in : trigger_in;
    e = enable && cur && !m_tprev;
    if (tserved) m_tpend = 0;
    if (e) begin
      if (m_tpend) lost_n++;
      else begin m_tpend = 1; m_tts = m_coarse; end
    end
    m_tprev = cur;
    m_lost = (m_lost + lost_n > 65535) ? 65535 : m_lost + lost_n;
    if (lost_n > 0) m_flag = 1;
    if (do_pop) void'(q.pop_front());
    if (have_word) q.push_back('{word, cyc + 1});
    m_coarse = (m_coarse + 1) % 4096;
  endtask

  // One clock: log any DUT pop, advance the model, then compare after the edge.
  task automatic step();
    bit exp_valid;
    if (out_valid && out_ready) begin
      dut_log.push_back(out_data);
      $display("pop ch=%0d trail=%0d coarse=%0d", out_data[17:13], out_data[12], out_data[11:0]);
    end
    if (rst) model_reset();
    else model_edge();
    cyc++;
    @(posedge clk);
    #1;
    exp_valid = (q.size() > 0) && (cyc >= q[0].wc + 1);
    chk("out_valid", out_valid, exp_valid);
    if (exp_valid) chk("out_data", out_data, q[0].w);
    chk("lost_cnt", lost_cnt, m_lost);
    chk("lost_flag", lost_flag, m_flag);
  endtask

  task automatic do_reset(input bit inverted);
    rst = 1'b1;
    inv = inverted;
    hit_in = inverted ? '1 : '0;
    trigger_in = inverted;
    enable = 1'b1; channel_mask = '1; edge_sel = 2'b01; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    dut_log.delete();
  endtask

  task automatic wait_coarse(input int v);
    int n;
    n = 0;
    while (m_coarse != v && n < 5000) begin step(); n++; end
    chk("wait_coarse", m_coarse, v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] tg;
    logic [DW-1:0]  w;
    int             ready_mode;
    cyc = 0;
    ready_mode = 0;
    model_reset();

    // Reset state
    do_reset(0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_lost", lost_cnt, 0);
    chk("rst_flag", lost_flag, 0);

    // Single leading edge on ch3 at coarse 100, two-cycle latency
    wait_coarse(100);
    hit_in[3] = 1'b1;
    step();
    chk("t1_lat0", out_valid, 0);
    hit_in[3] = 1'b0;
    step();
    chk("t1_lat1", out_valid, 0);
    step();
    chk("t1_lat2", out_valid, 1);
    chk("t1_word", out_data, mkw(3, 0, 100));

    // All channels rise together
    do_reset(0);
    hit_in = '1;
    step();
    repeat (30) step();
    chk("t2_count", dut_log.size(), 24);
    for (int i = 0; i < dut_log.size() && i < 24; i++) begin
      w = dut_log[i];
      chk("t2_ch", w[17:13], i);
      chk("t2_ts", w[11:0], 0);
    end
    chk("t2_lost", lost_cnt, 0);

    // FIFO full, ch5 held pending then lost
    do_reset(0);
    out_ready = 1'b0;
    hit_in[15:0] = '1;
    step();
    repeat (24) step();
    chk("t3_valid", out_valid, 1);
    hit_in[5] = 1'b0; step();
    hit_in[5] = 1'b1; step();
    hit_in[5] = 1'b0; step();
    hit_in[5] = 1'b1; step();
    chk("t3_lost", lost_cnt, 1);
    chk("t3_flag", lost_flag, 1);
    out_ready = 1'b1;
    repeat (30) step();
    chk("t3_count", dut_log.size(), 17);
    if (dut_log.size() >= 17) begin
      w = dut_log[16];
      chk("t3_last_ch", w[17:13], 5);
    end

    // Trigger and ch7 simultaneously
    do_reset(0);
    wait_coarse(200);
    hit_in[7] = 1'b1;
    trigger_in = 1'b1;
    step();
    hit_in[7] = 1'b0;
    trigger_in = 1'b0;
    repeat (8) step();
    chk("t4_count", dut_log.size(), 2);
    if (dut_log.size() >= 2) begin
      chk("t4_trig", dut_log[0], mkw(31, 0, 200));
      chk("t4_ch7", dut_log[1], mkw(7, 0, 200));
    end

    // Inverted polarity, both edges, coarse wrap
    do_reset(1);
    edge_sel = 2'b11;
    wait_coarse(4094);
    hit_in[2] = 1'b0;
    repeat (3) step();
    hit_in[2] = 1'b1;
    repeat (8) step();
    chk("t5_count", dut_log.size(), 2);
    if (dut_log.size() >= 2) begin
      chk("t5_lead", dut_log[0], mkw(2, 0, 4094));
      chk("t5_trail", dut_log[1], mkw(2, 1, 1));
    end

    // Reset with words queued and pending
    do_reset(0);
    out_ready = 1'b0;
    hit_in[7:0] = '1;
    step();
    repeat (5) step();
    chk("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    hit_in = '0;
    step();
    chk("t6_rst_valid", out_valid, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    dut_log.delete();
    repeat (20) step();
    chk("t6_no_stale", dut_log.size(), 0);
    chk("t6_lost", lost_cnt, 0);

    // Randomised traffic
    do_reset(0);
    for (int ci = 0; ci < 3000; ci++) begin
      tg = NCH'($urandom & $urandom & $urandom & $urandom);
      hit_in = hit_in ^ tg;
      if ($urandom_range(0, 7) == 0) trigger_in = ~trigger_in;
      if (ci % 200 == 0) edge_sel = 2'($urandom_range(0, 3));
      if (ci % 300 == 150) channel_mask = NCH'($urandom) | NCH'($urandom);
      if (ci % 500 == 250) inv = ~inv;
      if (ci % 100 == 0) begin
        enable = ($urandom_range(0, 4) != 0);
        ready_mode = $urandom_range(0, 2);
      end
      out_ready = (ready_mode == 0) ? 1'b1 :
                  (ready_mode == 1) ? ($urandom_range(0, 1) == 1) :
                                      ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
